// File: rtl/rtlola_event_queue_if.sv
// Bundled input/output signals of the RTLola input-event queue.
// The master side drives channel values and pop requests; the queue is the slave.
interface rtlola_event_queue_if #(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TS_W       = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                         en;
  logic [NUM_INPUTS*DATA_W-1:0] in_data;
  logic [NUM_INPUTS-1:0]        in_new;
  logic                         pop;
  logic [NUM_INPUTS*DATA_W-1:0] out_data;
  logic [NUM_INPUTS-1:0]        out_new;
  logic [TS_W-1:0]              out_ts;
  logic                         q_push;
  logic                         q_push_valid;
  logic                         q_pop;
  logic                         q_pop_valid;
  logic [CNT_W-1:0]             count;
  logic                         overflow;

  modport master (
    output en, in_data, in_new, pop,
    input  out_data, out_new, out_ts, q_push, q_push_valid, q_pop, q_pop_valid,
           count, overflow
  );

  modport slave (
    input  en, in_data, in_new, pop,
    output out_data, out_new, out_ts, q_push, q_push_valid, q_pop, q_pop_valid,
           count, overflow
  );
endinterface

// File: rtl/rtlola_event_queue.sv
// Timestamped input-event FIFO between RTLola stream inputs and the evaluator.
// Optional macro TIMESTAMP_DELTA_EN: out_ts reports the delta to the previously popped event.
module rtlola_event_queue #(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TS_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  rtlola_event_queue_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BUS_W = NUM_INPUTS * DATA_W;

  logic [BUS_W-1:0]      mem_data_q [DEPTH];
  logic [NUM_INPUTS-1:0] mem_new_q  [DEPTH];
  logic [TS_W-1:0]       mem_ts_q   [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [TS_W-1:0]       ts_q, ts_d;
  logic [BUS_W-1:0]      out_data_q, out_data_d;
  logic [NUM_INPUTS-1:0] out_new_q, out_new_d;
  logic [TS_W-1:0]       out_ts_q, out_ts_d;
  logic                  overflow_q, overflow_d;
`ifdef TIMESTAMP_DELTA_EN
  logic [TS_W-1:0]       last_ts_q, last_ts_d;
`endif

  logic                  push_c, push_valid_c;
  logic                  pop_c, pop_valid_c;
  logic                  full_c;
  logic [BUS_W-1:0]      entry_data_c;

  // Channels without a new value store zero so stale bus contents never leak out.
  always_comb begin
    entry_data_c = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (bus.in_new[i]) begin
        entry_data_c[i*DATA_W +: DATA_W] = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Handshake qualification; a pop only frees a slot when the queue is non-empty.
  always_comb begin
    push_c       = bus.en & (|bus.in_new);
    pop_c        = bus.en & bus.pop;
    full_c       = (count_q == CNT_W'(DEPTH));
    pop_valid_c  = pop_c & (count_q != '0);
    push_valid_c = push_c & (~full_c | pop_valid_c);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ts_d       = ts_q;
    out_data_d = out_data_q;
    out_new_d  = out_new_q;
    out_ts_d   = out_ts_q;
    overflow_d = overflow_q;
`ifdef TIMESTAMP_DELTA_EN
    last_ts_d  = last_ts_q;
`endif

    if (bus.en) begin
      ts_d = ts_q + TS_W'(1);
    end

    if (push_valid_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (push_c && !push_valid_c) begin
      overflow_d = 1'b1;
    end

    if (pop_valid_c) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      out_data_d = mem_data_q[rd_ptr_q];
      out_new_d  = mem_new_q[rd_ptr_q];
`ifdef TIMESTAMP_DELTA_EN
      out_ts_d   = mem_ts_q[rd_ptr_q] - last_ts_q;
      last_ts_d  = mem_ts_q[rd_ptr_q];
`else
      out_ts_d   = mem_ts_q[rd_ptr_q];
`endif
    end

    unique case ({push_valid_c, pop_valid_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ts_q       <= '0;
      out_data_q <= '0;
      out_new_q  <= '0;
      out_ts_q   <= '0;
      overflow_q <= 1'b0;
`ifdef TIMESTAMP_DELTA_EN
      last_ts_q  <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ts_q       <= ts_d;
      out_data_q <= out_data_d;
      out_new_q  <= out_new_d;
      out_ts_q   <= out_ts_d;
      overflow_q <= overflow_d;
`ifdef TIMESTAMP_DELTA_EN
      last_ts_q  <= last_ts_d;
`endif
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_valid_c) begin
      mem_data_q[wr_ptr_q] <= entry_data_c;
      mem_new_q[wr_ptr_q]  <= bus.in_new;
      mem_ts_q[wr_ptr_q]   <= ts_q;
    end
  end

  assign bus.q_push       = push_c;
  assign bus.q_push_valid = push_valid_c;
  assign bus.q_pop        = pop_c;
  assign bus.q_pop_valid  = pop_valid_c;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_new      = out_new_q;
  assign bus.out_ts       = out_ts_q;

endmodule

// File: tb/tb_rtlola_event_queue.sv
// Directed self-checking bench for rtlola_event_queue (2 channels, 64-bit, depth 4).
module tb_rtlola_event_queue;
  logic clk;
  logic rst;
  int unsigned passed;
  int unsigned total;

  rtlola_event_queue_if #(.NUM_INPUTS(2), .DATA_W(64), .DEPTH(4), .TS_W(32)) bus ();

  rtlola_event_queue #(.NUM_INPUTS(2), .DATA_W(64), .DEPTH(4), .TS_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Inputs change on the falling edge; combinational outputs are settled 1ns later.
  task automatic drive(input logic e, input logic [1:0] nw, input logic [63:0] d0,
                       input logic [63:0] d1, input logic p);
    @(negedge clk);
    bus.en      = e;
    bus.in_new  = nw;
    bus.in_data = {d1, d0};
    bus.pop     = p;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 2'b00, 64'd0, 64'd0, 1'b0);
    tick();
  endtask

  task automatic push(input logic [63:0] v);
    drive(1'b1, 2'b11, v, v, 1'b0);
    tick();
  endtask

  task automatic pop1();
    drive(1'b1, 2'b00, 64'd0, 64'd0, 1'b1);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b0;
    bus.en      = 1'b0;
    bus.in_new  = '0;
    bus.in_data = '0;
    bus.pop     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    passed      = 0;
    total       = 0;
    rst         = 1'b0;
    bus.en      = 1'b0;
    bus.in_new  = '0;
    bus.in_data = '0;
    bus.pop     = 1'b0;

    // Test 1: reset state, then a full event stamped after 10 enabled cycles
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data", bus.out_data[63:0], 64'd0);
    check("rst_out_new", 64'(bus.out_new), 64'd0);
    check("rst_out_ts", 64'(bus.out_ts), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) idle();
    drive(1'b1, 2'b11, 64'd1, 64'd1, 1'b0);
    check("t1_push_valid", 64'(bus.q_push_valid), 64'd1);
    tick();
    check("t1_count", 64'(bus.count), 64'd1);
    pop1();
    check("t1_ch0", bus.out_data[63:0], 64'd1);
    check("t1_ch1", bus.out_data[127:64], 64'd1);
    check("t1_new", 64'(bus.out_new), 64'd3);
    check("t1_ts", 64'(bus.out_ts), 64'd10);

    // Test 2: partial event masks the stale channel
    drive(1'b1, 2'b01, 64'd5, 64'd99, 1'b0);
    tick();
    pop1();
    check("t2_new", 64'(bus.out_new), 64'd1);
    check("t2_ch0", bus.out_data[63:0], 64'd5);
    check("t2_ch1", bus.out_data[127:64], 64'd0);
    check("t2_count", 64'(bus.count), 64'd0);

    // Test 3: overflow on the fifth push without pops
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 2'b11, 64'(k), 64'(k), 1'b0);
      check("t3_push", 64'(bus.q_push), 64'd1);
      check("t3_push_valid", 64'(bus.q_push_valid), (k <= 4) ? 64'd1 : 64'd0);
      tick();
    end
    check("t3_overflow", 64'(bus.overflow), 64'd1);
    check("t3_count_full", 64'(bus.count), 64'd4);
    for (int k = 1; k <= 4; k++) begin
      pop1();
      check("t3_pop_order", bus.out_data[63:0], 64'(k));
    end
    check("t3_count_empty", 64'(bus.count), 64'd0);
    check("t3_overflow_sticky", 64'(bus.overflow), 64'd1);

    // Test 4: full queue with simultaneous push and pop
    do_reset();
    check("t4_overflow_clr", 64'(bus.overflow), 64'd0);
    for (int k = 11; k <= 14; k++) push(64'(k));
    drive(1'b1, 2'b11, 64'd9, 64'd9, 1'b1);
    check("t4_push_valid", 64'(bus.q_push_valid), 64'd1);
    check("t4_pop_valid", 64'(bus.q_pop_valid), 64'd1);
    tick();
    check("t4_count", 64'(bus.count), 64'd4);
    check("t4_overflow", 64'(bus.overflow), 64'd0);
    check("t4_first", bus.out_data[63:0], 64'd11);
    pop1();
    check("t4_pop12", bus.out_data[63:0], 64'd12);
    pop1();
    check("t4_pop13", bus.out_data[63:0], 64'd13);
    pop1();
    check("t4_pop14", bus.out_data[63:0], 64'd14);
    pop1();
    check("t4_pop9", bus.out_data[63:0], 64'd9);

    // Test 5: empty-queue corner cases and reset with queued data
    drive(1'b1, 2'b11, 64'd7, 64'd7, 1'b1);
    check("t5_pop_valid", 64'(bus.q_pop_valid), 64'd0);
    check("t5_push_valid", 64'(bus.q_push_valid), 64'd1);
    tick();
    check("t5_count", 64'(bus.count), 64'd1);
    check("t5_out_hold", bus.out_data[63:0], 64'd9);
    pop1();
    check("t5_pop7", bus.out_data[63:0], 64'd7);
    drive(1'b1, 2'b00, 64'd0, 64'd0, 1'b1);
    check("t5_empty_pop", 64'(bus.q_pop_valid), 64'd0);
    tick();
    check("t5_empty_hold", bus.out_data[63:0], 64'd7);
    check("t5_empty_count", 64'(bus.count), 64'd0);
    push(64'd21);
    push(64'd22);
    check("t5_pre_rst_count", 64'(bus.count), 64'd2);
    do_reset();
    check("t5_rst_count", 64'(bus.count), 64'd0);
    check("t5_rst_out", bus.out_data[63:0], 64'd0);

    // Test 6: timestamps freeze while disabled
    repeat (3) idle();
    push(64'd3);
    repeat (4) idle();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 2'b11, 64'd1, 64'd1, 1'b1);
      if (k == 0) begin
        check("t6_q_push_off", 64'(bus.q_push), 64'd0);
        check("t6_q_pop_off", 64'(bus.q_pop), 64'd0);
      end
      tick();
    end
    check("t6_count_frozen", 64'(bus.count), 64'd1);
    push(64'd8);
    pop1();
    check("t6_ts_first", 64'(bus.out_ts), 64'd3);
    pop1();
    check("t6_val_second", bus.out_data[63:0], 64'd8);
`ifdef TIMESTAMP_DELTA_EN
    check("t6_ts_second", 64'(bus.out_ts), 64'd5);
`else
    check("t6_ts_second", 64'(bus.out_ts), 64'd8);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rtlola_event_queue.md
Name: rtlola_event_queue

Overview:
- Parametrised input-event buffer between the stream inputs and the monitor evaluation logic.
- Each cycle, any channels with a new-value flag are captured as one event. The event holds per-channel values, a new-flag mask and a cycle timestamp.
- Events are buffered in a FIFO of DEPTH entries and released one per pop request.
- Generalises the fixed two-input push/pop queue to NUM_INPUTS channels of DATA_W bits, adds timestamps, overflow detection and an occupancy count.

Parameters:
NUM_INPUTS, 2, number of input stream channels (1..16)
DATA_W, 64, width of each channel value (signed, two's complement)
DEPTH, 4, FIFO entries; power of two, 2..64
TS_W, 32, timestamp counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
en  in  1  global enable; 0 freezes all state
in_data  in  NUM_INPUTS*DATA_W  channel values, channel i at bits [i*DATA_W +: DATA_W]
in_new  in  NUM_INPUTS  new-value flag per channel
pop  in  1  evaluator requests next event
out_data  out  NUM_INPUTS*DATA_W  popped event values, registered
out_new  out  NUM_INPUTS  popped event new-flag mask, registered
out_ts  out  TS_W  popped event timestamp, registered
q_push  out  1  push attempted: en & |in_new
q_push_valid  out  1  push accepted this cycle
q_pop  out  1  pop attempted: en & pop
q_pop_valid  out  1  pop accepted this cycle
count  out  clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: an event was dropped

Behaviour:
- Reset (rst=0, asynchronous):
  - Write and read pointers, count, timestamp counter, out_data, out_new, out_ts and overflow all go to 0.
  - Release is synchronous to clk.
- Timestamp counter ts:
  - Increments by 1 every cycle with en=1; holds with en=0.
  - Wraps modulo 2^TS_W, with no flag on wrap.
- Event formation:
  - Entry = {ts at capture, in_new, in_data}.
  - Each channel whose in_new bit is 0 stores all-zero data, not the bus value.
- Push: q_push=1 and (count<DEPTH or q_pop_valid=1).
  - q_push_valid is combinational and asserted in the same cycle.
  - The entry is written at the clock edge.
- Pop: q_pop=1 and count>0.
  - q_pop_valid is combinational.
  - At the clock edge the head entry loads into out_data/out_new/out_ts and the read pointer advances.
  - Outputs hold their value until the next accepted pop.
- Latency:
  - Event presented at edge t is poppable from cycle t+1.
  - Its data is visible on the out_* ports after edge t+2.
  - There is no empty-queue bypass: push and pop on an empty queue accepts the push only, and q_pop_valid=0.
- Full queue:
  - Push with no simultaneous pop is dropped, q_push_valid=0, and overflow is set to 1 until reset.
  - Simultaneous push and pop is accepted; count is unchanged.
- count:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- Pointers: clog2(DEPTH) bits, natural wrap.
- en=0: q_push=q_pop=0; no state changes.
- Reset asserted mid-operation discards all queued events immediately.

Optional Feature:
TIMESTAMP_DELTA_EN:
- Defined: out_ts carries the difference between the popped event's timestamp and the previously popped event's timestamp, modulo 2^TS_W.
  - Requires an extra TS_W-bit last-popped register, reset to 0.
  - The first pop after reset therefore reports the absolute timestamp.
- Undefined: out_ts is the absolute capture timestamp.

Test Plan:
1. Reset sequence → all out_* ports, count and overflow are 0.
   - Hold rst=0 for 2 cycles, release, run 10 cycles with en=1 and no inputs.
   - Then inject in_new=2'b11, data (1,1) → q_push_valid=1, count=1.
   - Pop → out_data=(1,1), out_new=2'b11, out_ts=10.
2. Partial event.
   - Stimulus: in_new=2'b01, ch0=5, ch1 bus=99.
   - Required: popped out_new=2'b01, ch0=5, ch1=0.
3. Overflow, DEPTH=4.
   - Push 5 consecutive events with values 1..5, no pops → 5th has q_push_valid=0, overflow=1, count=4.
   - Four pops → values 1,2,3,4 in order, then count=0.
4. Full with simultaneous push and pop.
   - Fill 4 entries, then push 9 with pop in the same cycle.
   - Required: q_push_valid=1, q_pop_valid=1, count stays 4, overflow stays 0, 9 is popped last.
5. Empty edge cases.
   - Push and pop in the same cycle on an empty queue → q_pop_valid=0, count=1, out_* unchanged.
   - Pop with no events on an empty queue → q_pop_valid=0.
6. Enable gating and delta mode.
   - en=0 for 20 cycles between events at ts 3 and ts 8: timestamp frozen, second event stamped 8+20 only if en was high.
   - With TIMESTAMP_DELTA_EN, events at ts 100 and 1100 → out_ts = 100 then 1000.
